// File: rtl/bitwise_logic_pkg.sv
// Shared types and the bit-wise evaluation function for the logic pipe.
// The function works at a fixed maximum width; callers zero-extend and truncate.
package bitwise_logic_pkg;

  localparam int LOGIC_OP_COUNT = 8;
  localparam int LOGIC_MAX_W    = 256;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } logic_op_t;

  function automatic logic [LOGIC_MAX_W-1:0] logic_eval(
    input logic_op_t              op,
    input logic [LOGIC_MAX_W-1:0] a,
    input logic [LOGIC_MAX_W-1:0] b
  );
    logic [LOGIC_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register stage: loads when empty or when its contents leave
// in the same cycle, so bubbles collapse and full-rate streaming has no gaps.
module logic_pipe_stage
  import bitwise_logic_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         vld_r;
  logic [W-1:0] data_r;

  assign up_ready = !vld_r || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r  <= 1'b0;
      data_r <= '0;
    end else if (up_valid && up_ready) begin
      vld_r  <= 1'b1;
      data_r <= up_data;
    end else if (dn_ready) begin
      vld_r  <= 1'b0;
    end
  end

  assign dn_valid = vld_r;
  assign dn_data  = data_r;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined bit-wise logic unit: one of eight ops on a/b, result plus zero
// flag carried through LATENCY elastic stages with valid/ready on both ends.
module bitwise_logic_pipe
  import bitwise_logic_pkg::*;
#(
  parameter int N       = 32,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         zero
);

  if (N < 1 || N > LOGIC_MAX_W || LATENCY < 1 || LATENCY > 4) begin : g_param_check
    $error("bitwise_logic_pipe: illegal parameters N=%0d LATENCY=%0d", N, LATENCY);
  end

  logic [LOGIC_MAX_W-1:0] a_ext, b_ext;
  logic [N-1:0]           res_p0;
  logic                   zero_p0;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[N-1:0] = a;
    b_ext[N-1:0] = b;
  end

  assign res_p0  = N'(logic_eval(logic_op_t'(op), a_ext, b_ext));
  assign zero_p0 = (res_p0 == '0);

  // Stage boundary: index k is the input side of stage k, k+1 its output side.
  logic         vld_p [LATENCY+1];
  logic         rdy_p [LATENCY+1];
  logic [N:0]   dat_p [LATENCY+1];

  assign vld_p[0]       = in_valid;
  assign dat_p[0]       = {zero_p0, res_p0};
  assign rdy_p[LATENCY] = out_ready;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic_pipe_stage #(.W(N + 1)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vld_p[k]),
      .up_ready (rdy_p[k]),
      .up_data  (dat_p[k]),
      .dn_valid (vld_p[k+1]),
      .dn_ready (rdy_p[k+1]),
      .dn_data  (dat_p[k+1])
    );
  end

  assign in_ready  = rdy_p[0];
  assign out_valid = vld_p[LATENCY];
  assign c         = dat_p[LATENCY][N-1:0];
  assign zero      = dat_p[LATENCY][N];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed and randomised checks of bitwise_logic_pipe at three parameter points,
// with a scoreboard queue per instance.
module tb_bitwise_logic_pipe;
  import bitwise_logic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic rst;

  // Instance A: N=8, LATENCY=2
  logic       iv_a, ir_a, ov_a, ordy_a, z_a;
  logic [2:0] op_a;
  logic [7:0] a_a, b_a, c_a;
  // Instance B: N=1, LATENCY=1
  logic       iv_b, ir_b, ov_b, ordy_b, z_b;
  logic [2:0] op_b;
  logic [0:0] a_b, b_b, c_b;
  // Instance D: N=64, LATENCY=4
  logic        iv_d, ir_d, ov_d, ordy_d, z_d;
  logic [2:0]  op_d;
  logic [63:0] a_d, b_d, c_d;

  bitwise_logic_pipe #(.N(8), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .op(op_a), .a(a_a), .b(b_a),
    .out_valid(ov_a), .out_ready(ordy_a), .c(c_a), .zero(z_a));

  bitwise_logic_pipe #(.N(1), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .op(op_b), .a(a_b), .b(b_b),
    .out_valid(ov_b), .out_ready(ordy_b), .c(c_b), .zero(z_b));

  bitwise_logic_pipe #(.N(64), .LATENCY(4)) dut_d (
    .clk(clk), .rst(rst), .in_valid(iv_d), .in_ready(ir_d), .op(op_d), .a(a_d), .b(b_d),
    .out_valid(ov_d), .out_ready(ordy_d), .c(c_d), .zero(z_d));

  logic [64:0] qa [$];
  logic [64:0] qb [$];
  logic [64:0] qd [$];
  int n_out_a = 0, n_out_b = 0, n_out_d = 0;

  // Reference: {zero, result} for width w, encodings 0..7 = AND OR XOR NAND NOR XNOR ANDN PASSA
  function automatic logic [64:0] ref_model(input logic [2:0] o, input logic [63:0] x,
                                            input logic [63:0] y, input int w);
    logic [63:0] r, m;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x & ~y;
      default: r = x;
    endcase
    m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = r & m;
    return {(r == 64'd0), r};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic r);
    logic [64:0] e;
    @(negedge clk);
    iv_a = v; op_a = o; a_a = x; b_a = y; ordy_a = r;
    #1;
    if (ov_a && ordy_a) begin
      n_out_a++;
      if (qa.size() == 0) check("a_spurious_out", 65'd1, 65'd0);
      else begin
        e = qa.pop_front();
        check("a_result", {z_a, 56'd0, c_a}, e);
      end
    end
    if (iv_a && ir_a) qa.push_back(ref_model(o, {56'd0, x}, {56'd0, y}, 8));
  endtask

  task automatic step_bd(input logic vb, input logic [2:0] ob, input logic xb, input logic yb,
                         input logic rb, input logic vd, input logic [2:0] od,
                         input logic [63:0] xd, input logic [63:0] yd, input logic rd);
    logic [64:0] e;
    @(negedge clk);
    iv_b = vb; op_b = ob; a_b = xb; b_b = yb; ordy_b = rb;
    iv_d = vd; op_d = od; a_d = xd; b_d = yd; ordy_d = rd;
    #1;
    if (ov_b && ordy_b) begin
      n_out_b++;
      if (qb.size() == 0) check("b_spurious_out", 65'd1, 65'd0);
      else begin
        e = qb.pop_front();
        check("b_result", {z_b, 63'd0, c_b}, e);
      end
    end
    if (iv_b && ir_b) qb.push_back(ref_model(ob, {63'd0, xb}, {63'd0, yb}, 1));
    if (ov_d && ordy_d) begin
      n_out_d++;
      if (qd.size() == 0) check("d_spurious_out", 65'd1, 65'd0);
      else begin
        e = qd.pop_front();
        check("d_result", {z_d, c_d}, e);
      end
    end
    if (iv_d && ir_d) qd.push_back(ref_model(od, xd, yd, 64));
  endtask

  initial begin
    int lat_b, lat_d, cnt;
    rst = 1'b1;
    iv_a = 0; op_a = 0; a_a = 0; b_a = 0; ordy_a = 0;
    iv_b = 0; op_b = 0; a_b = 0; b_b = 0; ordy_b = 0;
    iv_d = 0; op_d = 0; a_d = 0; b_d = 0; ordy_d = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("a_rst_state", {ov_a, ir_a, z_a, c_a}, {1'b0, 1'b1, 1'b0, 8'h00});
    check("b_rst_state", {ov_b, ir_b, z_b, c_b}, {1'b0, 1'b1, 1'b0, 1'b0});
    check("d_rst_state", {ov_d, ir_d, z_d, c_d}, {1'b0, 1'b1, 1'b0, 64'd0});

    // Single NAND beat: out_valid one cycle after accept
    step_a(1, OP_NAND, 8'hF0, 8'hCC, 1);
    check("a_nand_accept", {64'd0, ir_a}, 65'd1);
    step_a(0, OP_AND, 8'h00, 8'h00, 1);
    check("a_nand_not_yet", {64'd0, ov_a}, 65'd0);
    step_a(0, OP_AND, 8'h00, 8'h00, 1);
    check("a_nand_valid", {64'd0, ov_a}, 65'd1);
    check("a_nand_value", {z_a, 56'd0, c_a}, {1'b0, 56'd0, 8'h3F});
    step_a(0, OP_AND, 8'h00, 8'h00, 1);
    check("a_nand_gone", {64'd0, ov_a}, 65'd0);

    // Stream all eight ops back to back
    cnt = n_out_a;
    for (int i = 0; i < LOGIC_OP_COUNT; i++) begin
      step_a(1, 3'(i), 8'hF0, 8'hCC, 1);
      check("a_stream_ready", {64'd0, ir_a}, 65'd1);
    end
    repeat (3) step_a(0, OP_AND, 8'h00, 8'h00, 1);
    check("a_stream_count", 65'(n_out_a - cnt), 65'd8);
    check("a_stream_final_idle", {64'd0, ov_a}, 65'd0);

    // XOR of equal operands gives zero
    step_a(1, OP_XOR, 8'hA5, 8'hA5, 1);
    step_a(0, OP_AND, 8'h00, 8'h00, 1);
    step_a(0, OP_AND, 8'h00, 8'h00, 1);
    check("a_xor_zero", {ov_a, z_a, c_a}, {1'b1, 1'b1, 8'h00});
    step_a(0, OP_AND, 8'h00, 8'h00, 1);

    // Back-pressure: two accepted, third stalls, output held
    step_a(1, OP_AND, 8'h12, 8'h34, 0);
    step_a(1, OP_OR,  8'h56, 8'h78, 0);
    check("a_bp_second_accept", {64'd0, ir_a}, 65'd1);
    step_a(1, OP_XOR, 8'h9A, 8'hBC, 0);
    check("a_bp_full_ready", {64'd0, ir_a}, 65'd0);
    check("a_bp_hold1", {ov_a, z_a, c_a}, {1'b1, 1'b0, 8'h10});
    step_a(1, OP_XOR, 8'h9A, 8'hBC, 0);
    check("a_bp_hold2", {ov_a, z_a, c_a}, {1'b1, 1'b0, 8'h10});
    step_a(1, OP_XOR, 8'h9A, 8'hBC, 1);
    check("a_bp_release_accept", {64'd0, ir_a}, 65'd1);
    cnt = n_out_a;
    repeat (3) step_a(0, OP_AND, 8'h00, 8'h00, 1);
    check("a_bp_drained", 65'(n_out_a - cnt), 65'd2);
    check("a_bp_queue_empty", 65'(qa.size()), 65'd0);

    // Reset with the pipe full and stalled
    step_a(1, OP_AND, 8'hFF, 8'hFF, 0);
    step_a(1, OP_OR,  8'h0F, 8'hF0, 0);
    step_a(0, OP_AND, 8'h00, 8'h00, 0);
    check("a_flush_full", {63'd0, ov_a, ir_a}, {63'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b1; iv_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; iv_a = 1'b0;
    qa.delete();
    #1;
    check("a_flush_state", {ov_a, ir_a, c_a}, {1'b0, 1'b1, 8'h00});
    repeat (3) begin
      step_a(0, OP_AND, 8'h00, 8'h00, 1);
      check("a_flush_no_ghost", {64'd0, ov_a}, 65'd0);
    end

    // Unstalled single-beat latency for LATENCY=1 and LATENCY=4
    lat_b = 0; lat_d = 0;
    step_bd(1, OP_XNOR, 1'b1, 1'b0, 1, 1, OP_ANDN, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_0F0F_0F0F, 1);
    for (int i = 1; i <= 6; i++) begin
      step_bd(0, OP_AND, 1'b0, 1'b0, 1, 0, OP_AND, 64'd0, 64'd0, 1);
      if (ov_b && lat_b == 0) lat_b = i;
      if (ov_d && lat_d == 0) lat_d = i;
    end
    check("b_latency", 65'(lat_b), 65'd1);
    check("d_latency", 65'(lat_d), 65'd4);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      step_bd($urandom_range(0, 9) < 7, 3'($urandom_range(0, LOGIC_OP_COUNT - 1)),
              1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 7, 3'($urandom_range(0, LOGIC_OP_COUNT - 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20; i++)
      step_bd(0, OP_AND, 1'b0, 1'b0, 1, 0, OP_AND, 64'd0, 64'd0, 1);
    check("b_random_drained", 65'(qb.size()), 65'd0);
    check("d_random_drained", 65'(qd.size()), 65'd0);
    check("b_random_traffic", {64'd0, n_out_b > 100}, 65'd1);
    check("d_random_traffic", {64'd0, n_out_d > 100}, 65'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
Name: bitwise_logic_pipe

Overview:
- Parametrised, pipelined successor to the single-function bit-wise gates. Executes one of eight bit-wise operations on two N-bit operands, selected per transaction.
- Result is registered through LATENCY elastic stages with valid/ready handshakes on both sides, plus a zero flag.
- Sits between operand sources (register file / ALU front end) and result consumers that can apply back-pressure.

Parameters:
- N, 32, operand/result width in bits (>=1).
- LATENCY, 2, number of register stages from accept to result presentation (1..4).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- op  input  3  operation select (logic_op_t).
- a  input  N  operand A.
- b  input  N  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- c  output  N  result C.
- zero  output  1  high when c == 0 (qualified by out_valid).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, c=0, zero=0, all stage valid bits=0, all stage data=0. in_ready=1 in the first cycle after reset.
- Operation encoding (logic_op_t): 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASSA (a).
- Result is computed combinationally from a, b and op, then captured in stage 0 on accept. Operands are not re-read later.
- zero is computed with the result and carried alongside it.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage rules, for k = 0..LATENCY-1:
  - Stage k loads when its upstream is valid and (stage k is empty OR stage k's contents leave this cycle).
  - Stage k's contents leave when they move to stage k+1, or when the last stage transfers out.
  - Bubbles collapse: an empty stage always accepts.
- in_ready = !v[0] || (stage 0 leaves this cycle). in_ready depends combinationally on out_ready through the stage chain. A skid register is not required.
- Latency: a transaction accepted at edge T appears with out_valid=1 after edge T+LATENCY-1, provided no back-pressure occurs.
- Throughput: one transaction per cycle while out_ready=1.
- Back-pressure: with out_ready=0, c, zero and out_valid hold stable until transfer. The pipe fills and in_ready drops once all LATENCY stages are valid.
- Simultaneous events: a full last stage with out_ready=1 and a valid upstream stage both transfer out and reload in the same cycle, with no bubble inserted.
- Ordering: strictly in-order; no transaction is dropped or duplicated.
- Reset mid-operation: all in-flight transactions are discarded. Outputs return to reset values on the following cycle regardless of in_valid or out_ready.
- While out_valid=0, c and zero hold their last value (0 after reset). Consumers ignore them.
- Illegal parameters (LATENCY outside 1..4, N<1) are rejected by an elaboration-time assertion.

Decomposition:
- Package bitwise_logic_pkg:
  - logic_op_t, a 3-bit enum with the values listed above.
  - Function logic_eval(op, a, b), generic over N via a parameterised class or a max width.
  - Constant LOGIC_OP_COUNT=8.
- Sub-module logic_pipe_stage: one elastic register stage (valid/ready, data N+1 bits), instantiated LATENCY times in a generate loop.
- Top level holds the op decode and stage chaining only.

Test Plan (N=8, LATENCY=2 unless stated):
- Reset, then a=0xF0, b=0xCC, op=NAND, out_ready=1, single-beat -> out_valid rises one cycle after accept; c=0x3F, zero=0.
- Back-to-back streaming of all 8 ops on a=0xF0, b=0xCC -> results in order 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0x30, 0xF0; one per cycle; in_ready stays 1.
- op=XOR, a=b=0xA5 -> c=0x00, zero=1.
- Hold out_ready=0 and drive 3 transactions -> first two accepted, in_ready=0 on the third. Output holds the first result stable. Release out_ready -> all three delivered in order with no loss.
- Assert rst for one cycle with the pipe full and out_ready=0 -> the next cycle shows out_valid=0, c=0, in_ready=1. The flushed results never appear.
- LATENCY=1 and LATENCY=4, N=1 and N=64: random op/a/b with random in_valid/out_ready -> scoreboard matches logic_eval for every transfer, and observed latency equals LATENCY when unstalled.
